if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage: owns the PC, issues requests to instruction memory, and registers fetched words into the IF/ID pipeline output (if_id_reg_t) consumed by the decode stage.
- Handles in-order variable-latency imem responses, pipeline stall from the hazard unit, and PC redirect (branch/jump) from EX, including discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold if_id_out this cycle
- redirect_valid  in  1  EX: taken branch/jump
- redirect_pc  in  XLEN  target PC; bits [1:0] ignored (treated as 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request this cycle
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  response valid; in order, earliest 1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- if_id_out  out  if_id_reg_t  registered {pc, instruction, valid_if_id} to decode

Behaviour:
- Async reset (reset=0): pc_q=RESET_PC, state=ISSUE, skid empty, if_id_out all-zero (valid_if_id=0); imem_req_valid=0 while reset is asserted. Imem is reset with this block; nothing is outstanding after reset.
- Max one outstanding request. FSM states ISSUE, WAIT, DROP.
- "Slot free" = !skid_valid && !stall.
- imem_req_valid = !redirect_valid && !skid_valid && (state==ISSUE || (state==WAIT && imem_rsp_valid && !stall)).
- imem_req_addr = pc_q. Requests may be withdrawn; acceptance is single-cycle valid&&ready.
- Request fire (valid && ready): fetch_pc_q<=pc_q, pc_q<=pc_q+4 (32-bit wrap, FFFF_FFFC -> 0000_0000), state->WAIT.
- ISSUE: no fire -> remain.
- WAIT, rsp and no redirect:
  - stall=0: if_id_out<={fetch_pc_q, rsp_data, 1}.
  - stall=1: word goes to skid.
  - Next state: WAIT if a new request fired the same cycle, else ISSUE.
- WAIT, no rsp: remain.
- DROP: rsp discarded -> ISSUE; no request issued in DROP.
- Output update, no redirect:
  - stall=1: if_id_out holds.
  - stall=0, skid valid: skid -> if_id_out, skid cleared.
  - stall=0, rsp accepted: as above.
  - stall=0, otherwise: if_id_out.valid_if_id<=0 (bubble; other fields don't-care, keep them).
- Redirect (highest priority; overrides stall):
  - pc_q<={redirect_pc[31:2],2'b00}; skid cleared; if_id_out.valid_if_id<=0; no request issued that cycle.
  - state->DROP if WAIT and no rsp this cycle; otherwise ISSUE (any same-cycle rsp discarded).
- Throughput: 1 instr/cycle with a 1-cycle imem and no stall. Latency: rsp in cycle M -> valid in if_id_out from M+1.
- Skid never overflows, because no request issues while it is full or while stall is asserted with a response pending.
- Reset mid-WAIT/DROP: state returns to ISSUE; any pre-reset response is undefined and not expected.

Decomposition:
- riscv_pkg: if_id_reg_t (existing), new fetch_state_t enum {FETCH_ISSUE, FETCH_WAIT, FETCH_DROP}, INSTR_BYTES=4 constant; XLEN from package.
- One sub-module: if_skid_buf (one-entry holding register, valid+pc+instr, with load/clear/pop).
- PC/FSM logic stays in if_stage.

Test Plan:
- Reset release, imem ready=1, 1-cycle rsp returning 0x00000013 -> requests 0x0,0x4,0x8 on consecutive cycles; if_id_out {0x0,0x13,1} then {0x4,..}, one per cycle.
- stall=1 for 3 cycles while rsp for pc 0x8 arrives -> if_id_out holds pc 0x4, 0x8 held in skid, no new request; stall=0 -> if_id_out pc 0x8 next cycle, then fetch resumes at 0xC.
- imem_req_ready=0 for 4 cycles -> imem_req_addr stable at 0x10, pc_q unchanged, if_id_out bubbles (valid=0).
- redirect_valid with redirect_pc=0x103 while WAIT for 0x20, rsp 2 cycles later -> stale 0x20 word never appears; next request addr 0x100, first valid output pc 0x100.
- redirect asserted together with stall=1 and skid full -> skid cleared, valid_if_id=0 next cycle, fetch from target.
- RESET_PC=32'hFFFF_FFF8 -> fetch addrs FFFF_FFF8, FFFF_FFFC, 0000_0000; reset asserted mid-WAIT -> outputs zero immediately (async), restart at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: XLEN, the IF/ID pipeline register and the fetch FSM states.
// Also holds a PC alignment helper so every stage forces word alignment the same way.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
    logic            valid_if_id;
  } if_id_reg_t;

  typedef enum logic [1:0] {
    FETCH_ISSUE,
    FETCH_WAIT,
    FETCH_DROP
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface if_stage_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched word that arrives while decode is stalled.
// clear (redirect flush) and pop (word consumed) both empty it and take priority over load.
module if_skid_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic            pop,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear || pop) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and registers fetched words into the IF/ID register, handling stall and EX redirects.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  if_stage_if.master        imem,
  output if_id_reg_t        if_id_out
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  if_id_reg_t      if_id_q, if_id_d;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic            skid_load, skid_clear, skid_pop;

  logic            req_fire;
  logic            rsp_accept;

  // A new request is only allowed when the skid is empty and, in WAIT, only when the
  // current response can go straight to decode; this is what keeps the skid from overflowing.
  assign imem.imem_req_valid = reset && !redirect_valid && !skid_valid &&
                               ((state_q == FETCH_ISSUE) ||
                                (state_q == FETCH_WAIT && imem.imem_rsp_valid && !stall));
  assign imem.imem_req_addr  = pc_q;

  assign req_fire   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_accept = (state_q == FETCH_WAIT) && imem.imem_rsp_valid && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    if_id_d    = if_id_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    skid_pop   = 1'b0;

    if (redirect_valid) begin
      pc_d                = align_pc(redirect_pc);
      skid_clear          = 1'b1;
      if_id_d.valid_if_id = 1'b0;
      state_d = (state_q == FETCH_WAIT && !imem.imem_rsp_valid) ? FETCH_DROP : FETCH_ISSUE;
    end else begin
      if (req_fire) begin
        fetch_pc_d = pc_q;
        pc_d       = pc_q + XLEN'(INSTR_BYTES);
      end

      unique case (state_q)
        FETCH_ISSUE: if (req_fire) state_d = FETCH_WAIT;
        FETCH_WAIT:  if (imem.imem_rsp_valid) state_d = req_fire ? FETCH_WAIT : FETCH_ISSUE;
        FETCH_DROP:  if (imem.imem_rsp_valid) state_d = FETCH_ISSUE;
        default:     state_d = FETCH_ISSUE;
      endcase

      // Skid contents are always older than any live response, so they drain first.
      if (stall) begin
        skid_load = rsp_accept;
      end else if (skid_valid) begin
        if_id_d.pc          = skid_pc;
        if_id_d.instruction = skid_instr;
        if_id_d.valid_if_id = 1'b1;
        skid_pop            = 1'b1;
      end else if (rsp_accept) begin
        if_id_d.pc          = fetch_pc_q;
        if_id_d.instruction = imem.imem_rsp_data;
        if_id_d.valid_if_id = 1'b1;
      end else begin
        if_id_d.valid_if_id = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH_ISSUE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      if_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      if_id_q    <= if_id_d;
    end
  end

  if_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .clear      (skid_clear),
    .pop        (skid_pop),
    .load_pc    (fetch_pc_q),
    .load_instr (imem.imem_rsp_data),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  assign if_id_out = if_id_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small in-order imem model feeds the main instance,
// a second instance checks RESET_PC wrap-around and asynchronous reset mid-fetch.
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        reset2;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  if_id_reg_t  out1;
  if_id_reg_t  out2;

  if_stage_if bus ();
  if_stage_if bus2 ();

  int checks = 0;
  int errors = 0;

  logic        pend;
  int          rsp_wait;
  logic [31:0] pend_addr;
  int          delay;
  logic        fired;
  logic [31:0] fire_addr;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus.master),
    .if_id_out      (out1)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .reset          (reset2),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus2.master),
    .if_id_out      (out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr);
    check({tag, ".valid"}, {31'd0, out1.valid_if_id}, {31'd0, v});
    if (v) begin
      check({tag, ".pc"}, out1.pc, pc);
      check({tag, ".instr"}, out1.instruction, instr);
    end
  endtask

  task automatic check_req(input string tag, input logic v, input logic [31:0] addr);
    check({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, {31'd0, v});
    if (v) check({tag, ".req_addr"}, bus.imem_req_addr, addr);
  endtask

  // Drive one cycle's inputs at the negedge, present any due response, let logic settle.
  task automatic apply_stimulus(input logic s, input logic rdy, input logic rv,
                                input logic [31:0] rpc);
    stall              = s;
    bus.imem_req_ready = rdy;
    redirect_valid     = rv;
    redirect_pc        = rpc;
    bus.imem_rsp_valid = pend && (rsp_wait == 0);
    bus.imem_rsp_data  = {pend_addr[23:0], 8'h13};
    #1;
    fired     = bus.imem_req_valid && bus.imem_req_ready;
    fire_addr = bus.imem_req_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    if (pend) begin
      if (rsp_wait == 0) pend = 1'b0;
      else rsp_wait--;
    end
    if (fired) begin
      pend      = 1'b1;
      pend_addr = fire_addr;
      rsp_wait  = delay - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; reset2 = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = '0;
    pend = 1'b0; rsp_wait = 0; pend_addr = '0; delay = 1; fired = 1'b0; fire_addr = '0;

    repeat (2) @(negedge clk);
    check("rst.req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst.out_pc", out1.pc, 32'd0);
    check("rst.out_instr", out1.instruction, 32'd0);
    check("rst.out_valid", {31'd0, out1.valid_if_id}, 32'd0);
    reset = 1'b1;

    // Back-to-back fetch with a 1-cycle imem
    apply_stimulus(0, 1, 0, 0); check_req("c0", 1, 32'h0);  check_out("c0", 0, 0, 0); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c1", 1, 32'h4);  check_out("c1", 0, 0, 0); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c2", 1, 32'h8);  check_out("c2", 1, 32'h0, 32'h13); tick();

    // Stall for three cycles while the word for 0x8 arrives
    apply_stimulus(1, 1, 0, 0); check_req("c3", 0, 0);      check_out("c3", 1, 32'h4, 32'h413); tick();
    apply_stimulus(1, 1, 0, 0); check_req("c4", 0, 0);      check_out("c4", 1, 32'h4, 32'h413); tick();
    apply_stimulus(1, 1, 0, 0); check_req("c5", 0, 0);      check_out("c5", 1, 32'h4, 32'h413); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c6", 0, 0);      check_out("c6", 1, 32'h4, 32'h413); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c7", 1, 32'hC);  check_out("c7", 1, 32'h8, 32'h813); tick();

    // imem not ready for four cycles
    apply_stimulus(0, 0, 0, 0); check_req("c8", 1, 32'h10);  check_out("c8", 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0); check_req("c9", 1, 32'h10);  check_out("c9", 1, 32'hC, 32'hC13); tick();
    apply_stimulus(0, 0, 0, 0); check_req("c10", 1, 32'h10); check_out("c10", 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0); check_req("c11", 1, 32'h10); check_out("c11", 0, 0, 0); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c12", 1, 32'h10); check_out("c12", 0, 0, 0); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c13", 1, 32'h14); check_out("c13", 0, 0, 0); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c14", 1, 32'h18); check_out("c14", 1, 32'h10, 32'h1013); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c15", 1, 32'h1C); check_out("c15", 1, 32'h14, 32'h1413); tick();

    // Redirect while waiting on a 2-cycle response for 0x20
    delay = 2;
    apply_stimulus(0, 1, 0, 0); check_req("c16", 1, 32'h20); check_out("c16", 1, 32'h18, 32'h1813); tick();
    delay = 1;
    apply_stimulus(0, 1, 1, 32'h103); check_req("c17", 0, 0); check_out("c17", 1, 32'h1C, 32'h1C13); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c18", 0, 0);       check_out("c18", 0, 0, 0); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c19", 1, 32'h100); check_out("c19", 0, 0, 0); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c20", 1, 32'h104); check_out("c20", 0, 0, 0); tick();
    apply_stimulus(0, 1, 0, 0); check_req("c21", 1, 32'h108); check_out("c21", 1, 32'h100, 32'h10013); tick();

    // Redirect with stall asserted and the skid holding 0x108
    apply_stimulus(1, 1, 0, 0);        check_req("c22", 0, 0);     check_out("c22", 1, 32'h104, 32'h10413); tick();
    apply_stimulus(1, 1, 1, 32'h200);  check_req("c23", 0, 0);     check_out("c23", 1, 32'h104, 32'h10413); tick();
    apply_stimulus(0, 1, 0, 0);        check_req("c24", 1, 32'h200); check_out("c24", 0, 0, 0); tick();
    apply_stimulus(0, 1, 0, 0);        check_req("c25", 1, 32'h204); check_out("c25", 0, 0, 0); tick();
    apply_stimulus(0, 0, 0, 0);        check_out("c26", 1, 32'h200, 32'h20013); tick();

    // Second instance: fetch wraps from FFFF_FFFC to 0000_0000
    reset2 = 1'b1;
    #1;
    check("w0.req_valid", {31'd0, bus2.imem_req_valid}, 32'd1);
    check("w0.req_addr", bus2.imem_req_addr, 32'hFFFF_FFF8);
    check("w0.out_valid", {31'd0, out2.valid_if_id}, 32'd0);
    @(negedge clk);
    bus2.imem_rsp_valid = 1'b1; bus2.imem_rsp_data = 32'hAAAA_0001;
    #1;
    check("w1.req_addr", bus2.imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    bus2.imem_rsp_data = 32'hAAAA_0002;
    #1;
    check("w2.req_valid", {31'd0, bus2.imem_req_valid}, 32'd1);
    check("w2.req_addr", bus2.imem_req_addr, 32'h0000_0000);
    check("w2.out_pc", out2.pc, 32'hFFFF_FFF8);
    check("w2.out_instr", out2.instruction, 32'hAAAA_0001);
    @(negedge clk);
    bus2.imem_rsp_valid = 1'b0;
    #1;
    check("w3.req_valid", {31'd0, bus2.imem_req_valid}, 32'd0);
    check("w3.out_pc", out2.pc, 32'hFFFF_FFFC);
    check("w3.out_valid", {31'd0, out2.valid_if_id}, 32'd1);

    // Asynchronous reset in the middle of WAIT
    #1 reset2 = 1'b0;
    #1;
    check("w4.out_valid", {31'd0, out2.valid_if_id}, 32'd0);
    check("w4.out_pc", out2.pc, 32'd0);
    check("w4.req_valid", {31'd0, bus2.imem_req_valid}, 32'd0);
    @(negedge clk);
    reset2 = 1'b1;
    #1;
    check("w5.req_valid", {31'd0, bus2.imem_req_valid}, 32'd1);
    check("w5.req_addr", bus2.imem_req_addr, 32'hFFFF_FFF8);
    check("w5.out_valid", {31'd0, out2.valid_if_id}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
